controle_pesagem_uc: RTL and testbench

- Control unit (FSM) that sequences the weighing datapath.
- Frames incoming serial bytes into one weight packet and evaluates the interval/zero flags once the packet is complete.
- Steps the servo position up or down, one position per interval tick, through the up/down counter.
- Sits beside the datapath. It consumes the datapath's byte-valid, command and comparator flags. It drives the updown counter, the interval counter and the servo reset.

---
 rtl/controle_pesagem_uc_pkg.sv | 20 ++
 rtl/controle_pesagem_uc_contador_bytes_quadro.sv | 36 +++
 rtl/controle_pesagem_uc.sv | 135 +++++++++++++
 tb/tb_controle_pesagem_uc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pesagem_uc_pkg.sv
// Shared encodings and sizing for the weighing control unit and its byte counter.
package controle_pesagem_uc_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    ESPERA_QUADRO = 4'd1,
    RECEBE        = 4'd2,
    AVALIA        = 4'd3,
    MOVE          = 4'd4,
    MOVE_CHECK    = 4'd5,
    FIM           = 4'd6,
    ERRO          = 4'd7
  } estado_t;

  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam int N_BYTES = 6;
  localparam int POS_MAX = 7;
  localparam int POS_W   = 3;

endpackage

// File: rtl/controle_pesagem_uc_contador_bytes_quadro.sv
// Counts data bytes of one packet; fim flags the increment that completes the packet.
module contador_bytes_quadro #(
  parameter int N_BYTES = controle_pesagem_uc_pkg::N_BYTES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic fim_o
);
  import controle_pesagem_uc_pkg::*;

  localparam int CNT_W = $clog2(N_BYTES + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fim_o = inc_i & (count_q == CNT_W'(N_BYTES - 1));

endmodule

// File: rtl/controle_pesagem_uc.sv
// Control FSM of the weighing datapath: frames a '#' packet, evaluates the flags
// and steps the servo position toward the selected end, one step per interval tick.
module controle_pesagem_uc #(
  parameter int N_BYTES = controle_pesagem_uc_pkg::N_BYTES,
  parameter int POS_MAX = controle_pesagem_uc_pkg::POS_MAX,
  parameter int POS_W   = controle_pesagem_uc_pkg::POS_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dado_valido,
  input  logic             comando,
  input  logic             pertence_intervalo,
  input  logic             peso_max_zero,
  input  logic             fim_intervalo,
  input  logic [POS_W-1:0] posicao,
  output logic             reset_updown,
  output logic             conta_updown,
  output logic             sentido,
  output logic             conta_intervalo,
  output logic             zera_intervalo,
  output logic             zera_pwm,
  output logic             pronto,
  output logic             erro,
  output logic [3:0]       db_estado
);
  import controle_pesagem_uc_pkg::*;

  localparam logic [POS_W-1:0] POS_TOPO = POS_W'(POS_MAX);

  estado_t          estado_q, estado_d;
  logic             sentido_q, sentido_d;
  logic             erro_q, erro_d;
  logic             conta_updown_q, conta_updown_d;
  logic             conta_int_q, conta_int_d;
  logic             zera_int_q, reset_updown_q, zera_pwm_q, pronto_q;
  logic             quadro, cnt_inc, cnt_fim;
  logic [POS_W-1:0] alvo, alvo_aval, pos_passo;

  assign quadro  = dado_valido & comando;
  assign cnt_inc = (estado_q == RECEBE) & dado_valido & ~comando;

  contador_bytes_quadro #(.N_BYTES(N_BYTES)) u_contador (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (quadro),
    .inc_i (cnt_inc),
    .fim_o (cnt_fim)
  );

  assign alvo      = sentido_q ? POS_TOPO : '0;
  assign alvo_aval = pertence_intervalo ? POS_TOPO : '0;
  // Position the counter will hold once the pending step lands.
  assign pos_passo = sentido_q ? posicao + 1'b1 : posicao - 1'b1;

  always_comb begin
    estado_d       = estado_q;
    sentido_d      = sentido_q;
    erro_d         = erro_q;
    conta_updown_d = 1'b0;
    conta_int_d    = 1'b0;
    case (estado_q)
      INICIAL:       estado_d = ESPERA_QUADRO;
      ESPERA_QUADRO: if (quadro) estado_d = RECEBE;
      RECEBE:        if (cnt_fim) estado_d = AVALIA;
      AVALIA: begin
        if (quadro) begin
          estado_d = RECEBE;
        end else if (peso_max_zero) begin
          erro_d   = 1'b1;
          estado_d = ERRO;
        end else begin
          erro_d      = 1'b0;
          sentido_d   = pertence_intervalo;
          estado_d    = MOVE;
          conta_int_d = (posicao != alvo_aval);
        end
      end
      MOVE: begin
        // Target check precedes the tick so a coincident tick never overshoots.
        if (quadro) begin
          estado_d = RECEBE;
        end else if (posicao == alvo) begin
          estado_d = FIM;
        end else begin
          conta_int_d = 1'b1;
          if (fim_intervalo) begin
            conta_updown_d = 1'b1;
            estado_d       = MOVE_CHECK;
          end
        end
      end
      MOVE_CHECK: begin
        estado_d    = quadro ? RECEBE : MOVE;
        conta_int_d = ~quadro & (pos_passo != alvo);
      end
      FIM, ERRO:     estado_d = quadro ? RECEBE : ESPERA_QUADRO;
      default:       estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= INICIAL;
      sentido_q      <= 1'b0;
      erro_q         <= 1'b0;
      conta_updown_q <= 1'b0;
      conta_int_q    <= 1'b0;
      zera_int_q     <= 1'b1;
      reset_updown_q <= 1'b1;
      zera_pwm_q     <= 1'b1;
      pronto_q       <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      sentido_q      <= sentido_d;
      erro_q         <= erro_d;
      conta_updown_q <= conta_updown_d;
      conta_int_q    <= conta_int_d;
      zera_int_q     <= ~conta_int_d;
      reset_updown_q <= (estado_d == INICIAL) || (estado_d == ERRO);
      zera_pwm_q     <= (estado_d == INICIAL) || erro_d;
      pronto_q       <= (estado_d == FIM);
    end
  end

  assign reset_updown    = reset_updown_q;
  assign conta_updown    = conta_updown_q;
  assign sentido         = sentido_q;
  assign conta_intervalo = conta_int_q;
  assign zera_intervalo  = zera_int_q;
  assign zera_pwm        = zera_pwm_q;
  assign pronto          = pronto_q;
  assign erro            = erro_q;
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_controle_pesagem_uc.sv
// Bench for controle_pesagem_uc with models of the up/down and interval counters.
`timescale 1ns/1ps
module tb_controle_pesagem_uc;
  import controle_pesagem_uc_pkg::*;

  localparam int IVL = 20;

  logic clock = 1'b0, reset = 1'b1;
  logic dado_valido = 1'b0, comando = 1'b0;
  logic pertence_intervalo = 1'b0, peso_max_zero = 1'b0, fim_force = 1'b0;
  logic fim_intervalo;
  logic [POS_W-1:0] posicao, pos_m = '0;
  logic reset_updown, conta_updown, sentido, conta_intervalo, zera_intervalo, zera_pwm, pronto, erro;
  logic [3:0] db_estado;
  int icnt = 0, total_steps = 0, total_pronto = 0, total_overshoot = 0;
  int checks = 0, failures = 0;

  typedef struct { bit is_err; bit sentido; int steps; int pos; } exp_t;
  exp_t sb[$];

  controle_pesagem_uc dut (
    .clock(clock), .reset(reset), .dado_valido(dado_valido), .comando(comando),
    .pertence_intervalo(pertence_intervalo), .peso_max_zero(peso_max_zero),
    .fim_intervalo(fim_intervalo), .posicao(posicao), .reset_updown(reset_updown),
    .conta_updown(conta_updown), .sentido(sentido), .conta_intervalo(conta_intervalo),
    .zera_intervalo(zera_intervalo), .zera_pwm(zera_pwm), .pronto(pronto), .erro(erro),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Environment: position counter, interval counter and event tallies.
  always @(posedge clock) begin
    if (conta_updown === 1'b1) begin
      total_steps <= total_steps + 1;
      if (pos_m == (sentido ? POS_W'(POS_MAX) : '0)) total_overshoot <= total_overshoot + 1;
    end
    if (pronto === 1'b1) total_pronto <= total_pronto + 1;
    if (reset_updown === 1'b1) pos_m <= '0;
    else if (conta_updown === 1'b1) pos_m <= sentido ? pos_m + 1'b1 : pos_m - 1'b1;
    if (zera_intervalo === 1'b1) icnt <= 0;
    else if (conta_intervalo === 1'b1) icnt <= (icnt == IVL - 1) ? 0 : icnt + 1;
  end
  assign fim_intervalo = fim_force | (conta_intervalo & (icnt == IVL - 1));
  assign posicao = pos_m;

  function automatic exp_t model_packet(input int pmin, input int pmax, input int patual, input int pos);
    exp_t e;
    e.is_err  = (pmax == 0);
    e.sentido = (pmin <= patual) && (patual <= pmax);
    if (e.is_err) begin e.steps = 0; e.pos = 0; end
    else if (e.sentido) begin e.steps = POS_MAX - pos; e.pos = POS_MAX; end
    else begin e.steps = pos; e.pos = 0; end
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_weights(input int pmin, input int pmax, input int patual);
    pertence_intervalo = (pmin <= patual) && (patual <= pmax);
    peso_max_zero      = (pmax == 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    dado_valido = 1'b1;
    comando     = (b == ASCII_HASH);
    @(negedge clock);
    dado_valido = 1'b0;
    comando     = 1'b0;
  endtask

  task automatic send_data(input int n);
    for (int i = 0; i < n; i++) send_byte(8'h30 + 8'(i));
  endtask

  task automatic wait_done(input int max_cyc, output bit to);
    to = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (pronto === 1'b1 || db_estado === 4'(ERRO)) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++; if (db_estado !== 4'(INICIAL)) begin failures++; $display("FAIL rst_estado got=%0d exp=%0d", db_estado, 0); end
    checks++; if (reset_updown !== 1'b1) begin failures++; $display("FAIL rst_reset_updown got=%b exp=1", reset_updown); end
    checks++; if (zera_intervalo !== 1'b1) begin failures++; $display("FAIL rst_zera_intervalo got=%b exp=1", zera_intervalo); end
    checks++; if (zera_pwm !== 1'b1) begin failures++; $display("FAIL rst_zera_pwm got=%b exp=1", zera_pwm); end
    checks++; if ({conta_updown, conta_intervalo, pronto, erro, sentido} !== 5'b0) begin
      failures++; $display("FAIL rst_outs got=%b exp=00000", {conta_updown, conta_intervalo, pronto, erro, sentido}); end
    reset = 1'b0;
    tick(1);
    checks++; if (db_estado !== 4'(ESPERA_QUADRO)) begin failures++; $display("FAIL rst_to_espera got=%0d exp=%0d", db_estado, 1); end
    checks++; if (reset_updown !== 1'b0 || zera_pwm !== 1'b0 || zera_intervalo !== 1'b1) begin
      failures++; $display("FAIL espera_outs got=%b%b%b exp=001", reset_updown, zera_pwm, zera_intervalo); end
  endtask

  task automatic test_idle_ignore();
    int s0;
    s0 = total_steps;
    send_byte(8'h41);
    send_byte(8'h42);
    checks++; if (db_estado !== 4'(ESPERA_QUADRO)) begin failures++; $display("FAIL idle_bytes got=%0d exp=%0d", db_estado, 1); end
    fim_force = 1'b1;
    tick(3);
    fim_force = 1'b0;
    tick(2);
    checks++; if (total_steps - s0 !== 0) begin failures++; $display("FAIL idle_fim_steps got=%0d exp=0", total_steps - s0); end
    checks++; if (db_estado !== 4'(ESPERA_QUADRO)) begin failures++; $display("FAIL idle_fim_estado got=%0d exp=%0d", db_estado, 1); end
  endtask

  task automatic test_move_packet(input string tag, input int pmin, input int pmax, input int patual);
    int s0, p0, o0;
    bit to;
    exp_t e;
    set_weights(pmin, pmax, patual);
    sb.push_back(model_packet(pmin, pmax, patual, int'(pos_m)));
    s0 = total_steps; p0 = total_pronto; o0 = total_overshoot;
    send_byte(ASCII_HASH);
    send_data(N_BYTES);
    checks++; if (db_estado !== 4'(AVALIA)) begin failures++; $display("FAIL %s_avalia got=%0d exp=%0d", tag, db_estado, 3); end
    tick(1);
    e = sb[0];
    checks++; if (db_estado !== 4'(MOVE)) begin failures++; $display("FAIL %s_move got=%0d exp=%0d", tag, db_estado, 4); end
    checks++; if (conta_intervalo !== (e.steps != 0)) begin failures++; $display("FAIL %s_conta_int got=%b exp=%b", tag, conta_intervalo, e.steps != 0); end
    checks++; if (erro !== 1'b0) begin failures++; $display("FAIL %s_erro got=%b exp=0", tag, erro); end
    wait_done(POS_MAX * (IVL + 4) + 40, to);
    checks++; if (to) begin failures++; $display("FAIL %s_timeout got=%b exp=0", tag, to); end
    e = sb.pop_front();
    checks++; if (sentido !== e.sentido) begin failures++; $display("FAIL %s_sentido got=%b exp=%b", tag, sentido, e.sentido); end
    checks++; if (total_steps - s0 !== e.steps) begin failures++; $display("FAIL %s_steps got=%0d exp=%0d", tag, total_steps - s0, e.steps); end
    checks++; if (int'(pos_m) !== e.pos) begin failures++; $display("FAIL %s_pos got=%0d exp=%0d", tag, pos_m, e.pos); end
    tick(IVL * 2);
    checks++; if (total_pronto - p0 !== 1) begin failures++; $display("FAIL %s_pronto_count got=%0d exp=1", tag, total_pronto - p0); end
    checks++; if (total_steps - s0 !== e.steps) begin failures++; $display("FAIL %s_no_extra_step got=%0d exp=%0d", tag, total_steps - s0, e.steps); end
    checks++; if (total_overshoot - o0 !== 0) begin failures++; $display("FAIL %s_overshoot got=%0d exp=0", tag, total_overshoot - o0); end
    checks++; if (db_estado !== 4'(ESPERA_QUADRO) || zera_pwm !== 1'b0) begin
      failures++; $display("FAIL %s_idle got=%0d/%b exp=1/0", tag, db_estado, zera_pwm); end
  endtask

  task automatic test_restart();
    int s0;
    bit to;
    exp_t e;
    set_weights(10, 50, 30);
    sb.push_back(model_packet(10, 50, 30, int'(pos_m)));
    s0 = total_steps;
    send_byte(ASCII_HASH);
    send_data(3);
    send_byte(ASCII_HASH);
    send_data(N_BYTES - 1);
    checks++; if (db_estado !== 4'(RECEBE)) begin failures++; $display("FAIL restart_recebe got=%0d exp=%0d", db_estado, 2); end
    send_data(1);
    checks++; if (db_estado !== 4'(AVALIA)) begin failures++; $display("FAIL restart_avalia got=%0d exp=%0d", db_estado, 3); end
    wait_done(POS_MAX * (IVL + 4) + 40, to);
    e = sb.pop_front();
    checks++; if (to) begin failures++; $display("FAIL restart_timeout got=%b exp=0", to); end
    checks++; if (total_steps - s0 !== e.steps || int'(pos_m) !== e.pos) begin
      failures++; $display("FAIL restart_move got=%0d/%0d exp=%0d/%0d", total_steps - s0, pos_m, e.steps, e.pos); end
    tick(3);
  endtask

  task automatic test_peso_max_zero();
    int s0;
    bit to;
    exp_t e;
    set_weights(0, 0, 5);
    sb.push_back(model_packet(0, 0, 5, int'(pos_m)));
    s0 = total_steps;
    send_byte(ASCII_HASH);
    send_data(N_BYTES);
    wait_done(20, to);
    e = sb.pop_front();
    checks++; if (to) begin failures++; $display("FAIL zero_timeout got=%b exp=0", to); end
    checks++; if ((db_estado === 4'(ERRO)) !== e.is_err) begin failures++; $display("FAIL zero_estado got=%0d exp=%0d", db_estado, 7); end
    checks++; if (erro !== 1'b1 || zera_pwm !== 1'b1 || reset_updown !== 1'b1 || conta_updown !== 1'b0) begin
      failures++; $display("FAIL zero_outs got=%b%b%b%b exp=1110", erro, zera_pwm, reset_updown, conta_updown); end
    tick(1);
    checks++; if (reset_updown !== 1'b0 || erro !== 1'b1) begin failures++; $display("FAIL zero_after got=%b%b exp=01", reset_updown, erro); end
    checks++; if (db_estado !== 4'(ESPERA_QUADRO)) begin failures++; $display("FAIL zero_espera got=%0d exp=%0d", db_estado, 1); end
    checks++; if (int'(pos_m) !== e.pos || total_steps - s0 !== e.steps) begin
      failures++; $display("FAIL zero_pos got=%0d/%0d exp=%0d/%0d", pos_m, total_steps - s0, e.pos, e.steps); end
  endtask

  task automatic test_abort_move();
    int s0;
    bit to;
    exp_t e;
    set_weights(10, 50, 30);
    s0 = total_steps;
    send_byte(ASCII_HASH);
    send_data(N_BYTES);
    to = 1'b1;
    for (int i = 0; i < 4 * (IVL + 4); i++) begin
      if (total_steps - s0 == 3) begin to = 1'b0; break; end
      @(negedge clock);
    end
    checks++; if (to) begin failures++; $display("FAIL abort_wait got=%0d exp=3", total_steps - s0); end
    e.is_err = 1'b0; e.sentido = 1'b1; e.steps = 3; e.pos = 3;
    sb.push_back(e);
    send_byte(ASCII_HASH);
    checks++; if (db_estado !== 4'(RECEBE) || conta_updown !== 1'b0) begin
      failures++; $display("FAIL abort_recebe got=%0d/%b exp=2/0", db_estado, conta_updown); end
    tick(IVL * 3);
    e = sb.pop_front();
    checks++; if (total_steps - s0 !== e.steps) begin failures++; $display("FAIL abort_steps got=%0d exp=%0d", total_steps - s0, e.steps); end
    checks++; if (int'(pos_m) !== e.pos) begin failures++; $display("FAIL abort_pos got=%0d exp=%0d", pos_m, e.pos); end
    checks++; if (db_estado !== 4'(RECEBE) || conta_intervalo !== 1'b0) begin
      failures++; $display("FAIL abort_hold got=%0d/%b exp=2/0", db_estado, conta_intervalo); end
    sb.push_back(model_packet(10, 50, 30, int'(pos_m)));
    s0 = total_steps;
    send_data(N_BYTES);
    wait_done(POS_MAX * (IVL + 4) + 40, to);
    e = sb.pop_front();
    checks++; if (to || total_steps - s0 !== e.steps || int'(pos_m) !== e.pos) begin
      failures++; $display("FAIL abort_resume got=%0d/%0d exp=%0d/%0d", total_steps - s0, pos_m, e.steps, e.pos); end
    tick(3);
  endtask

  task automatic test_reset_mid_move();
    int s0;
    bit to;
    set_weights(10, 50, 80);
    s0 = total_steps;
    send_byte(ASCII_HASH);
    send_data(N_BYTES);
    to = 1'b1;
    for (int i = 0; i < 3 * (IVL + 4); i++) begin
      if (total_steps - s0 == 2) begin to = 1'b0; break; end
      @(negedge clock);
    end
    checks++; if (to) begin failures++; $display("FAIL rstmv_wait got=%0d exp=2", total_steps - s0); end
    reset = 1'b1;
    tick(1);
    checks++; if (db_estado !== 4'(INICIAL)) begin failures++; $display("FAIL rstmv_estado got=%0d exp=0", db_estado); end
    checks++; if (reset_updown !== 1'b1 || zera_pwm !== 1'b1 || conta_intervalo !== 1'b0) begin
      failures++; $display("FAIL rstmv_outs got=%b%b%b exp=110", reset_updown, zera_pwm, conta_intervalo); end
    reset = 1'b0;
    tick(2);
    checks++; if (pos_m !== '0 || db_estado !== 4'(ESPERA_QUADRO)) begin
      failures++; $display("FAIL rstmv_after got=%0d/%0d exp=0/1", pos_m, db_estado); end
    checks++; if (total_steps - s0 !== 2) begin failures++; $display("FAIL rstmv_steps got=%0d exp=2", total_steps - s0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_move_packet("in_range", 10, 50, 30);
    test_move_packet("out_range", 10, 50, 80);
    test_restart();
    test_peso_max_zero();
    test_move_packet("after_err", 10, 50, 80);
    test_abort_move();
    test_reset_mid_move();
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
